alu_seq: RTL and testbench

Parametrised, clocked multi-cycle ALU: the next generation of the team's combinational `ALU`. Operand width is configurable, the opcode space grows to eight, and the block adds iterative unsigned multiply and divide behind a valid/ready handshake. It sits between an operand-issuing controller and a result consumer, taking one operation at a time and returning a registered result with a one-cycle `o_valid` pulse.

---
 rtl/alu_seq_if.sv | 23 ++
 rtl/alu_seq.sv | 133 +++++++++++++
 tb/tb_alu_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response bundle between operand issuer, alu_seq and result consumer
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic                 i_valid;
   logic [WIDTH-1:0]     i_a;
   logic [WIDTH-1:0]     i_b;
   logic [2:0]           i_control;
   logic                 o_ready;
   logic                 o_valid;
   logic [2*WIDTH:0]     o_out;
   logic                 o_err;

   modport master (
      output i_valid, i_a, i_b, i_control,
      input  o_ready, o_valid, o_out, o_err
   );

   modport slave (
      input  i_valid, i_a, i_b, i_control,
      output o_ready, o_valid, o_out, o_err
   );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with iterative shift-add multiply and restoring divide
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic      i_clk,
   input  logic      i_rst,
   alu_seq_if.slave  bus
);
   localparam int OW = 2 * WIDTH + 1;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t             state, state_next;
   logic [WIDTH-1:0]   opa, opb;
   logic [2:0]         op;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] work;
   logic [OW-1:0]      out_q;
   logic               err_q;
   logic               valid_q;

   logic               iterative, last, finish;
   logic [WIDTH:0]     mul_sum, div_t, div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] mul_work, div_work, step;
   logic [OW-1:0]      res;
   logic               res_err;

   // work holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
   assign mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opa} : '0);
   assign mul_work = {mul_sum, work[WIDTH-1:1]};
   assign div_t    = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
   assign div_ge   = div_t >= {1'b0, opb};
   assign div_diff = div_t - {1'b0, opb};
   assign div_work = {(div_ge ? div_diff[WIDTH-1:0] : div_t[WIDTH-1:0]), work[WIDTH-2:0], div_ge};
   assign step     = (op == OP_MUL) ? mul_work : div_work;

   assign iterative = (op == OP_MUL) || ((op == OP_DIV) && (opb != '0));
   assign last      = !iterative || (cnt == CW'(WIDTH - 1));
   assign finish    = (state == EXEC) && last;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.i_valid) state_next = EXEC;
         EXEC:    if (last) state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      res     = '0;
      res_err = 1'b0;
      case (op)
         OP_ADD: res = OW'(opa) + OW'(opb);
         OP_SUB: res = OW'(opa) - OW'(opb);
         OP_MUL: res = {1'b0, mul_work};
         OP_DIV: begin
            if (opb == '0) begin
               res     = {1'b0, opa, {WIDTH{1'b1}}};
               res_err = 1'b1;
            end else begin
               res = {1'b0, div_work};
            end
         end
         OP_AND: res = OW'(opa & opb);
         OP_OR:  res = OW'(opa | opb);
         OP_XOR: res = OW'(opa ^ opb);
         default: begin
            res     = '0;
            res_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         opa     <= '0;
         opb     <= '0;
         op      <= '0;
         cnt     <= '0;
         work    <= '0;
         out_q   <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= finish;
         case (state)
            IDLE: begin
               if (bus.i_valid) begin
                  opa  <= bus.i_a;
                  opb  <= bus.i_b;
                  op   <= bus.i_control;
                  cnt  <= '0;
                  work <= (bus.i_control == OP_DIV) ? {{WIDTH{1'b0}}, bus.i_a}
                                                    : {{WIDTH{1'b0}}, bus.i_b};
               end
            end
            EXEC: begin
               if (iterative) begin
                  work <= step;
                  cnt  <= cnt + CW'(1);
               end
               if (last) begin
                  out_q <= res;
                  err_q <= res_err;
                  cnt   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_ready = (state == IDLE);
   assign bus.o_valid = valid_q;
   assign bus.o_out   = out_q;
   assign bus.o_err   = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=8
module tb_alu_seq;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(8)) bus ();
   alu_seq #(.WIDTH(8)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // returns {err, out}
   function automatic logic [17:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [16:0] r;
      logic        e;
      int          ia, ib;
      ia = a;
      ib = b;
      r  = '0;
      e  = 1'b0;
      case (op)
         3'd0: r = 17'(ia + ib);
         3'd1: r = 17'(ia - ib);
         3'd2: r = 17'(ia * ib);
         3'd3: begin
            if (ib == 0) begin
               r = {1'b0, a, 8'hFF};
               e = 1'b1;
            end else begin
               r = 17'((ia % ib) * 256 + ia / ib);
            end
         end
         3'd4: r = 17'(a & b);
         3'd5: r = 17'(a | b);
         3'd6: r = 17'(a ^ b);
         default: e = 1'b1;
      endcase
      return {e, r};
   endfunction

   task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [16:0] exp_out, input logic exp_err);
      int   lat;
      int   exp_lat;
      logic ready_low;
      exp_lat = (op == 3'd2 || (op == 3'd3 && b != 8'd0)) ? 8 : 1;
      @(negedge clk);
      check({tag, " ready before"}, 32'(bus.o_ready), 32'd1);
      bus.i_valid   = 1'b1;
      bus.i_a       = a;
      bus.i_b       = b;
      bus.i_control = op;
      @(negedge clk);
      bus.i_valid = 1'b0;
      lat       = 0;
      ready_low = 1'b1;
      while (bus.o_valid !== 1'b1 && lat < 40) begin
         if (bus.o_ready !== 1'b0) ready_low = 1'b0;
         bus.i_a       = 8'($urandom);
         bus.i_b       = 8'($urandom);
         bus.i_control = 3'($urandom);
         @(negedge clk);
         lat++;
      end
      if (bus.o_ready !== 1'b0) ready_low = 1'b0;
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " out"}, 32'(bus.o_out), 32'(exp_out));
      check({tag, " err"}, 32'(bus.o_err), 32'(exp_err));
      check({tag, " ready low while busy"}, 32'(ready_low), 32'd1);
      @(negedge clk);
      check({tag, " valid single pulse"}, 32'(bus.o_valid), 32'd0);
      check({tag, " ready after"}, 32'(bus.o_ready), 32'd1);
      check({tag, " out held"}, 32'(bus.o_out), 32'(exp_out));
   endtask

   initial begin
      logic [17:0] m;
      logic [17:0] q[$];
      logic [2:0]  rop;
      logic [7:0]  ra, rb;
      int          acc, vld, seen;

      rst           = 1'b1;
      bus.i_valid   = 1'b1;
      bus.i_a       = 8'd1;
      bus.i_b       = 8'd2;
      bus.i_control = 3'd0;
      repeat (2) @(negedge clk);
      check("reset ready", 32'(bus.o_ready), 32'd1);
      check("reset valid", 32'(bus.o_valid), 32'd0);
      check("reset out", 32'(bus.o_out), 32'd0);
      check("reset err", 32'(bus.o_err), 32'd0);
      bus.i_valid = 1'b0;
      rst         = 1'b0;

      do_op("add max", 3'd0, 8'd255, 8'd255, 17'h001FE, 1'b0);
      do_op("sub borrow", 3'd1, 8'd3, 8'd5, 17'h1FFFE, 1'b0);
      do_op("sub plain", 3'd1, 8'd5, 8'd3, 17'h00002, 1'b0);
      do_op("mul max", 3'd2, 8'd255, 8'd255, 17'h0FE01, 1'b0);
      do_op("div 200/7", 3'd3, 8'd200, 8'd7, 17'h0041C, 1'b0);
      do_op("div by zero", 3'd3, 8'd13, 8'd0, 17'h00DFF, 1'b1);
      do_op("illegal", 3'd7, 8'd99, 8'd42, 17'h00000, 1'b1);
      do_op("div 255/1", 3'd3, 8'd255, 8'd1, 17'h000FF, 1'b0);
      do_op("div 5/9", 3'd3, 8'd5, 8'd9, 17'h00500, 1'b0);

      // reset lands on edge k+4 of a multiply
      @(negedge clk);
      bus.i_valid   = 1'b1;
      bus.i_a       = 8'd255;
      bus.i_b       = 8'd255;
      bus.i_control = 3'd2;
      @(negedge clk);
      bus.i_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort valid", 32'(bus.o_valid), 32'd0);
      check("abort out", 32'(bus.o_out), 32'd0);
      check("abort err", 32'(bus.o_err), 32'd0);
      check("abort ready", 32'(bus.o_ready), 32'd1);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.o_valid === 1'b1) seen++;
      end
      check("abort no late valid", 32'(seen), 32'd0);
      do_op("and after abort", 3'd4, 8'hF0, 8'h3C, 17'h00030, 1'b0);

      for (int i = 0; i < 150; i++) begin
         rop = 3'($urandom);
         ra  = 8'($urandom);
         rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         m   = model(rop, ra, rb);
         do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, m[16:0], m[17]);
      end

      // i_valid held high: every accept must produce exactly one result, in order
      acc = 0;
      vld = 0;
      seen = 0;
      for (int c = 0; c < 4000 + 30; c++) begin
         @(negedge clk);
         if (bus.o_valid === 1'b1) begin
            vld++;
            if (seen == 1) check("sweep back-to-back valid", 32'd1, 32'(seen - 1));
            check("sweep result pending", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
               m = q.pop_front();
               check("sweep out", 32'(bus.o_out), 32'(m[16:0]));
               check("sweep err", 32'(bus.o_err), 32'(m[17]));
            end
            seen = 1;
         end else begin
            seen = 0;
         end
         bus.i_valid   = (c < 4000);
         bus.i_control = 3'($urandom);
         bus.i_a       = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
         bus.i_b       = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         if (bus.o_ready === 1'b1 && bus.i_valid) begin
            q.push_back(model(bus.i_control, bus.i_a, bus.i_b));
            acc++;
         end
      end
      check("sweep valid count", 32'(vld), 32'(acc));
      check("sweep queue drained", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
